data_packer: RTL and testbench
==============================

Name: data_packer

Overview:
- Downstream consumer of the byte synchroniser stage.
- Takes the synchronised byte stream (8-bit data plus a one-cycle qualifier per byte) and packs BYTES_PER_WORD bytes into one word.
- Presents each word on a valid/ready output port, backed by a 2-entry output FIFO.
- The upstream stage has no backpressure, so when the FIFO cannot absorb a word the loss is flagged, not stalled.

Parameters:
- BYTES_PER_WORD, 4, bytes packed per output word; legal range 2..8.
- DW, 8*BYTES_PER_WORD, output word width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- din  in  8  byte from the synchroniser stage
- din_valid  in  1  byte qualifier; one byte accepted per high cycle
- dout  out  DW  packed word; head of the FIFO
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts; a pop occurs when dout_valid && dout_ready
- byte_cnt  out  $clog2(BYTES_PER_WORD)  bytes held in the partial word
- overflow  out  1  sticky; a completed word was dropped

Behaviour:
- Reset (rst sampled high at posedge):
  - Partial word, byte_cnt, FIFO pointers and overflow all clear to 0.
  - dout_valid=0 and dout=0.
  - rst overrides every other input in the same cycle.
- Packing order is little-endian: the byte accepted with byte_cnt=k lands in bits [8k+7:8k].
- Accumulating: on each din_valid, the byte is written at slot byte_cnt and byte_cnt increments.
- Completing: when din_valid arrives with byte_cnt=BYTES_PER_WORD-1:
  - The assembled word, including this byte, is pushed to the FIFO at the same edge.
  - byte_cnt wraps to 0.
  - The partial register is not cleared. Unused slots are overwritten before they are reused.
- Latency: dout_valid rises on the cycle after the edge that accepts the final byte (1 clk), provided the FIFO was empty.
- FIFO:
  - 2 entries, first-in first-out.
  - dout shows the head entry combinationally from the registers.
  - dout holds its value while dout_valid && !dout_ready.
- Full, push without pop: the completed word is dropped and overflow is set to 1 and held until rst. FIFO contents are unchanged and byte_cnt still wraps to 0.
- Full, push with pop in the same cycle: both occur, nothing is dropped, and overflow is unchanged.
- Empty with a push: the word becomes visible next cycle. There is no fall-through in the same cycle.
- Pop when empty: impossible by definition, since dout_ready is ignored while dout_valid=0.
- din_valid=0: no state change in the packer. The FIFO may still pop.
- Reset mid-word: the partial bytes are discarded, and the next word starts at slot 0.
- Packing proceeds regardless of dout_ready. Only FIFO occupancy causes drops.

Optional Feature:
- Macro: DATA_PACKER_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit) and output dout_nbytes ($clog2(BYTES_PER_WORD)+1 bits, carried per FIFO entry).
  - flush=1 with byte_cnt>0 pushes the partial word. Unfilled upper bytes are 0 and nbytes=byte_cnt. byte_cnt then goes to 0.
  - flush with din_valid in the same cycle: the byte is included first, then the word is pushed, with nbytes=byte_cnt+1 (or BYTES_PER_WORD on a natural completion).
  - flush with byte_cnt=0 and no din_valid has no effect.
  - Full words carry nbytes=BYTES_PER_WORD.
  - Drop and overflow rules are identical to a normal push.
- Undefined: no flush port and no dout_nbytes. Only full words are emitted.

Decomposition:
- Package data_packer_pkg:
  - FIFO_DEPTH=2.
  - Helper constants for count widths.
  - Typedef of the FIFO entry struct: word, plus nbytes when the flush feature is enabled.
- Sub-module pack_fifo2:
  - 2-entry register FIFO with push/pop/full/empty.
  - Simultaneous push+pop when full is supported.
- The top level holds the packer counter, partial register and overflow logic.

Test Plan:
- Basic packing: rst 2 cycles; dout_ready=1; din=0x11,0x22,0x33,0x44 on consecutive cycles -> dout=0x44332211, dout_valid=1 for exactly 1 cycle, one cycle after the 0x44 edge; byte_cnt returns to 0.
- Backpressure/overflow: dout_ready=0; send 12 bytes 0x01..0x0C:
  - dout=0x04030201 is held.
  - The second entry is 0x08070605.
  - overflow=1 after the 12th byte.
  - Then dout_ready=1 -> pops 0x04030201, then 0x08070605, then dout_valid=0; overflow stays 1.
- Full with simultaneous push/pop: fill the FIFO, then raise dout_ready in the cycle the third word completes -> no drop, overflow=0, three words out in order.
- Reset mid-word: send 0xAA,0xBB, pulse rst, then send 0x01..0x04 -> dout=0x04030201 and byte_cnt=0 after reset.
- Gapped input: bytes 0x11..0x44 with din_valid idle cycles between them -> same word 0x44332211; dout_valid is not asserted early.
- Flush (DATA_PACKER_FLUSH_EN): send 0x55,0x66, then flush=1 -> dout=0x00006655, dout_nbytes=2; byte_cnt=0.

Source files
------------

// File: rtl/data_packer_pkg.sv
// Shared constants and FIFO entry type for the byte-to-word packer.
// DATA_PACKER_FLUSH_EN adds a per-entry byte count to the FIFO entry.
package data_packer_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_BPW    = 8;
  localparam int MAX_DW     = 8 * MAX_BPW;
  localparam int MAX_NB_W   = $clog2(MAX_BPW) + 1;

  function automatic int cnt_width(input int bpw);
    return $clog2(bpw);
  endfunction

  function automatic int nbytes_width(input int bpw);
    return $clog2(bpw) + 1;
  endfunction

  // Entries are sized for the largest legal word; narrower builds leave upper bits at 0.
  typedef struct packed {
    logic [MAX_DW-1:0]   word;
`ifdef DATA_PACKER_FLUSH_EN
    logic [MAX_NB_W-1:0] nbytes;
`endif
  } fifo_entry_t;

endpackage

// File: rtl/pack_fifo2.sv
// Two-entry register FIFO; head is read combinationally from the storage registers.
// A push while full is accepted only when a pop happens on the same edge.
module pack_fifo2
  import data_packer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t data_i,
  input  logic        pop_i,
  output fifo_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  fifo_entry_t mem_q [FIFO_DEPTH];
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  cnt_q;
  logic        push_ok;
  logic        pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      // When full, wr_q == rd_q: the slot being written is the one being popped.
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/data_packer.sv
// Packs a qualified byte stream little-endian into words and queues them in a 2-entry FIFO.
// DATA_PACKER_FLUSH_EN adds a flush input and a per-word dout_nbytes output.
module data_packer
  import data_packer_pkg::*;
#(
  parameter  int BYTES_PER_WORD = 4,
  localparam int DW  = 8 * BYTES_PER_WORD,
  localparam int CW  = cnt_width(BYTES_PER_WORD),
  localparam int NBW = nbytes_width(BYTES_PER_WORD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    din,
  input  logic          din_valid,
`ifdef DATA_PACKER_FLUSH_EN
  input  logic          flush,
  output logic [NBW-1:0] dout_nbytes,
`endif
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] byte_cnt,
  output logic          overflow
);

  // Output handshake: a word transfers on each rising edge where dout_valid && dout_ready;
  // dout_valid never depends on dout_ready, and dout is stable while valid && !ready.

  logic [DW-1:0] part_q, part_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  fifo_entry_t   push_entry;
  fifo_entry_t   head_entry;
`ifdef DATA_PACKER_FLUSH_EN
  logic [NBW-1:0] flush_nb;
`endif

  always_comb begin
    part_d     = part_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_entry = '0;
    if (din_valid) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (cnt_q == CW'(i)) part_d[8*i +: 8] = din;
      end
      if (cnt_q == CW'(BYTES_PER_WORD - 1)) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    push_entry.word[DW-1:0] = part_d;
`ifdef DATA_PACKER_FLUSH_EN
    flush_nb = {1'b0, cnt_q} + NBW'(din_valid);
    push_entry.nbytes[NBW-1:0] = NBW'(BYTES_PER_WORD);
    // A flush on a natural completion is just the full word; otherwise zero the unfilled bytes.
    if (flush && !push && (flush_nb != '0)) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (NBW'(i) >= flush_nb) push_entry.word[8*i +: 8] = 8'h00;
      end
      push_entry.nbytes[NBW-1:0] = flush_nb;
      push  = 1'b1;
      cnt_d = '0;
    end
`endif
  end

  assign pop   = dout_valid && dout_ready;
  assign ovf_d = ovf_q | (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      part_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      part_q <= part_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  pack_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dout       = head_entry.word[DW-1:0];
  assign dout_valid = !fifo_empty;
  assign byte_cnt   = cnt_q;
  assign overflow   = ovf_q;

  generate
    if (DW < MAX_DW) begin : g_word_hi
      logic unused_word_hi;
      assign unused_word_hi = ^head_entry.word[MAX_DW-1:DW];
    end
  endgenerate

`ifdef DATA_PACKER_FLUSH_EN
  assign dout_nbytes = head_entry.nbytes[NBW-1:0];
  generate
    if (NBW < MAX_NB_W) begin : g_nb_hi
      logic unused_nb_hi;
      assign unused_nb_hi = ^head_entry.nbytes[MAX_NB_W-1:NBW];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_data_packer.sv
// Self-checking bench for data_packer: scoreboard of expected words checked on every pop.
// Exercises the flush path as well when DATA_PACKER_FLUSH_EN is defined.
module tb_data_packer;

  localparam int BPW = 4;
  localparam int DW  = 8 * BPW;
  localparam int CW  = $clog2(BPW);
  localparam int NBW = CW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    din;
  logic          din_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] byte_cnt;
  logic          overflow;
`ifdef DATA_PACKER_FLUSH_EN
  logic           flush;
  logic [NBW-1:0] dout_nbytes;
  logic [NBW-1:0] nb_q[$];
  logic [NBW-1:0] exp_nb;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;

  data_packer #(.BYTES_PER_WORD(BPW)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
`ifdef DATA_PACKER_FLUSH_EN
    .flush       (flush),
    .dout_nbytes (dout_nbytes),
`endif
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .byte_cnt    (byte_cnt),
    .overflow    (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [DW-1:0] w, input int nb);
    exp_q.push_back(w);
`ifdef DATA_PACKER_FLUSH_EN
    nb_q.push_back(NBW'(nb));
`else
    if (nb < 0) $display("negative byte count %0d", nb);
`endif
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      idle(1);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still expected, required 0", exp_q.size());
    end
  endtask

  // scoreboard: compare on every cycle where a pop will occur
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: dout=%h with no word expected", dout);
      end else begin
        exp_w = exp_q.pop_front();
        if (dout !== exp_w) begin
          errors++;
          $display("FAIL pop_word: got %h required %h", dout, exp_w);
        end
`ifdef DATA_PACKER_FLUSH_EN
        exp_nb = nb_q.pop_front();
        checks++;
        if (dout_nbytes !== exp_nb) begin
          errors++;
          $display("FAIL pop_nbytes: got %0d required %0d", dout_nbytes, exp_nb);
        end
`endif
      end
    end
  end

  task automatic test_reset();
    reset_dut(2);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", dout_valid); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h required 0", dout); end
    checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", byte_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", overflow); end
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    expect_word(32'h44332211, BPW);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_early: valid=%b required 0", dout_valid); end
    send_byte(8'h44);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: valid=%b required 1", dout_valid); end
    checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL basic_cnt: got %0d required 0", byte_cnt); end
    idle(1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: valid=%b required 0", dout_valid); end
    wait_drain();
  endtask

  task automatic test_overflow();
    dout_ready = 1'b0;
    expect_word(32'h04030201, BPW);
    expect_word(32'h08070605, BPW);
    for (int i = 1; i <= 12; i++) begin
      send_byte(8'(i));
      if (i == 11) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b required 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
    checks++; if (dout !== 32'h04030201) begin errors++; $display("FAIL ovf_hold: got %h required 04030201", dout); end
    checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL ovf_cnt: got %0d required 0", byte_cnt); end
    dout_ready = 1'b1;
    wait_drain();
    idle(1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: valid=%b required 0", dout_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_back_to_back();
    reset_dut(1);
    dout_ready = 1'b0;
    expect_word(32'h04030201, BPW);
    expect_word(32'h08070605, BPW);
    expect_word(32'h0C0B0A09, BPW);
    for (int i = 1; i <= 11; i++) send_byte(8'(i));
    dout_ready = 1'b1;
    send_byte(8'h0C);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b required 0", overflow); end
    wait_drain();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_end: got %b required 0", overflow); end
  endtask

  task automatic test_reset_mid_word();
    dout_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    checks++; if (byte_cnt !== CW'(2)) begin errors++; $display("FAIL mid_cnt: got %0d required 2", byte_cnt); end
    reset_dut(1);
    checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL mid_cnt_rst: got %0d required 0", byte_cnt); end
    expect_word(32'h04030201, BPW);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    wait_drain();
  endtask

  task automatic test_gapped();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    dout_ready = 1'b1;
    expect_word(32'h44332211, BPW);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(1, 3));
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL gap_early: valid=%b before byte %0d", dout_valid, i); end
      send_byte(bytes[i]);
    end
    wait_drain();
  endtask

`ifdef DATA_PACKER_FLUSH_EN
  task automatic test_flush();
    dout_ready = 1'b1;
    flush = 1'b0;
    expect_word(32'h00006655, 2);
    send_byte(8'h55);
    send_byte(8'h66);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL flush_cnt: got %0d required 0", byte_cnt); end
    wait_drain();
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: valid=%b required 0", dout_valid); end
    expect_word(32'h00000077, 1);
    flush = 1'b1;
    send_byte(8'h77);
    flush = 1'b0;
    wait_drain();
    expect_word(32'hDDCCBBAA, 4);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    flush = 1'b1;
    send_byte(8'hDD);
    flush = 1'b0;
    wait_drain();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
`ifdef DATA_PACKER_FLUSH_EN
    flush      = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid_word();
    test_gapped();
`ifdef DATA_PACKER_FLUSH_EN
    test_flush();
`endif
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: %0d words, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
